decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: one-cycle RV32I/RV64I integer decoder.
// Output side is a single registered bundle with valid/ready handshake,
// flush, and a saturating counter of illegal instructions handed downstream.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_reg_write,
  output logic             out_mem_read,
  output logic             out_mem_write,
  output logic             out_mem_unsigned,
  output logic             out_branch,
  output logic             out_jump,
  output logic             out_alu_src_imm,
  output logic             out_illegal,
  output logic [1:0]       out_mem_size,
  output logic [3:0]       out_alu_op,
  output logic [CNT_W-1:0] illegal_count
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_unsigned;
    logic            branch;
    logic            jump;
    logic            alu_src_imm;
    logic            illegal;
    logic [1:0]      mem_size;
    logic [3:0]      alu_op;
  } bundle_t;

  // Widen a 32-bit immediate to XLEN by replicating bit 31. Going through a
  // 64-bit temporary avoids a zero-width replication when XLEN is 32.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [63:0] w;
    w = {{32{v[31]}}, v};
    return w[XLEN-1:0];
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
  logic        legal;
  logic        capture;
  bundle_t     dec_raw, dec;
  bundle_t     bundle_d, bundle_q;
  logic        out_valid_d, out_valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Instruction fields and the five immediate formats, 32 bits wide
  always_comb begin
    opcode  = in_insn[6:0];
    funct3  = in_insn[14:12];
    funct7  = in_insn[31:25];
    imm_i32 = {{20{in_insn[31]}}, in_insn[31:20]};
    imm_s32 = {{20{in_insn[31]}}, in_insn[31:25], in_insn[11:7]};
    imm_b32 = {{19{in_insn[31]}}, in_insn[31], in_insn[7], in_insn[30:25],
               in_insn[11:8], 1'b0};
    imm_u32 = {in_insn[31:12], 12'b0};
    imm_j32 = {{11{in_insn[31]}}, in_insn[31], in_insn[19:12], in_insn[20],
               in_insn[30:21], 1'b0};
  end

  // Opcode/funct decode into a control bundle, legality tracked alongside
  always_comb begin
    dec_raw     = '0;
    dec_raw.pc  = in_pc;
    dec_raw.rd  = in_insn[11:7];
    dec_raw.rs1 = in_insn[19:15];
    dec_raw.rs2 = in_insn[24:20];
    legal       = 1'b1;
    case (opcode)
      OPC_LOAD: begin
        dec_raw.mem_read     = 1'b1;
        dec_raw.reg_write    = 1'b1;
        dec_raw.mem_size     = funct3[1:0];
        dec_raw.mem_unsigned = funct3[2];
        dec_raw.alu_op       = ALU_ADD;
        dec_raw.alu_src_imm  = 1'b1;
        dec_raw.imm          = sext32(imm_i32);
        if (funct3 == 3'b111) legal = 1'b0;
        // LD and LWU only exist on RV64
        if (!RV64 && (funct3 == 3'b011 || funct3 == 3'b110)) legal = 1'b0;
      end
      OPC_STORE: begin
        dec_raw.mem_write   = 1'b1;
        dec_raw.mem_size    = funct3[1:0];
        dec_raw.alu_op      = ALU_ADD;
        dec_raw.alu_src_imm = 1'b1;
        dec_raw.imm         = sext32(imm_s32);
        if (funct3[2]) legal = 1'b0;
        if (!RV64 && funct3[1:0] == 2'b11) legal = 1'b0;
      end
      OPC_OPIMM: begin
        dec_raw.reg_write   = 1'b1;
        dec_raw.alu_src_imm = 1'b1;
        dec_raw.imm         = sext32(imm_i32);
        case (funct3)
          3'b000: dec_raw.alu_op = ALU_ADD;
          3'b010: dec_raw.alu_op = ALU_SLT;
          3'b011: dec_raw.alu_op = ALU_SLTU;
          3'b100: dec_raw.alu_op = ALU_XOR;
          3'b110: dec_raw.alu_op = ALU_OR;
          3'b111: dec_raw.alu_op = ALU_AND;
          3'b001: begin
            dec_raw.alu_op = ALU_SLL;
            if (funct7[6:1] != 6'b000000) legal = 1'b0;
          end
          default: begin
            dec_raw.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            if (funct7[6:1] != 6'b000000 && funct7[6:1] != 6'b010000) legal = 1'b0;
          end
        endcase
        // shamt[5] only addresses a valid bit position on RV64
        if (!RV64 && funct3[1:0] == 2'b01 && in_insn[25]) legal = 1'b0;
      end
      OPC_OP: begin
        dec_raw.reg_write = 1'b1;
        case (funct3)
          3'b000:  dec_raw.alu_op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001:  dec_raw.alu_op = ALU_SLL;
          3'b010:  dec_raw.alu_op = ALU_SLT;
          3'b011:  dec_raw.alu_op = ALU_SLTU;
          3'b100:  dec_raw.alu_op = ALU_XOR;
          3'b101:  dec_raw.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  dec_raw.alu_op = ALU_OR;
          default: dec_raw.alu_op = ALU_AND;
        endcase
        if (funct7 == 7'b0100000) begin
          if (funct3 != 3'b000 && funct3 != 3'b101) legal = 1'b0;
        end else if (funct7 != 7'b0000000) begin
          legal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_raw.reg_write   = 1'b1;
        dec_raw.alu_op      = ALU_PASSB;
        dec_raw.alu_src_imm = 1'b1;
        dec_raw.imm         = sext32(imm_u32);
      end
      OPC_AUIPC: begin
        dec_raw.reg_write   = 1'b1;
        dec_raw.alu_op      = ALU_ADD;
        dec_raw.alu_src_imm = 1'b1;
        dec_raw.imm         = sext32(imm_u32);
      end
      OPC_JAL: begin
        dec_raw.reg_write   = 1'b1;
        dec_raw.jump        = 1'b1;
        dec_raw.alu_op      = ALU_ADD;
        dec_raw.alu_src_imm = 1'b1;
        dec_raw.imm         = sext32(imm_j32);
      end
      OPC_JALR: begin
        dec_raw.reg_write   = 1'b1;
        dec_raw.jump        = 1'b1;
        dec_raw.alu_op      = ALU_ADD;
        dec_raw.alu_src_imm = 1'b1;
        dec_raw.imm         = sext32(imm_i32);
        if (funct3 != 3'b000) legal = 1'b0;
      end
      OPC_BRANCH: begin
        dec_raw.branch = 1'b1;
        dec_raw.imm    = sext32(imm_b32);
        case (funct3[2:1])
          2'b00:   dec_raw.alu_op = ALU_SUB;
          2'b10:   dec_raw.alu_op = ALU_SLT;
          2'b11:   dec_raw.alu_op = ALU_SLTU;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (in_insn[1:0] != 2'b11) legal = 1'b0;
  end

  // Illegal words keep only their identifying fields; rd=x0 never writes back
  always_comb begin
    dec = dec_raw;
    if (!legal) begin
      dec         = '0;
      dec.pc      = dec_raw.pc;
      dec.rd      = dec_raw.rd;
      dec.rs1     = dec_raw.rs1;
      dec.rs2     = dec_raw.rs2;
      dec.illegal = 1'b1;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // Output register next-state: flush beats capture beats drain/hold
  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Count illegal bundles as they are handed over, sticking at all-ones
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && out_ready && bundle_q.illegal && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_pc           = bundle_q.pc;
  assign out_rd           = bundle_q.rd;
  assign out_rs1          = bundle_q.rs1;
  assign out_rs2          = bundle_q.rs2;
  assign out_imm          = bundle_q.imm;
  assign out_reg_write    = bundle_q.reg_write;
  assign out_mem_read     = bundle_q.mem_read;
  assign out_mem_write    = bundle_q.mem_write;
  assign out_mem_unsigned = bundle_q.mem_unsigned;
  assign out_branch       = bundle_q.branch;
  assign out_jump         = bundle_q.jump;
  assign out_alu_src_imm  = bundle_q.alu_src_imm;
  assign out_illegal      = bundle_q.illegal;
  assign out_mem_size     = bundle_q.mem_size;
  assign out_alu_op       = bundle_q.alu_op;
  assign illegal_count    = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: RV64 and RV32 decoders driven in lockstep by the same
// stimulus; a scoreboard queue of expected bundle pairs is checked by a
// negedge monitor whenever the decoders present output.
module tb_decode_stage;
  localparam int CW = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_unsigned;
    logic        branch;
    logic        jump;
    logic        alu_src_imm;
    logic        illegal;
    logic [1:0]  mem_size;
    logic [3:0]  alu_op;
  } bundle_t;

  typedef struct packed {
    bundle_t e64;
    bundle_t e32;
  } pair_t;

  logic        clk, rst_n, in_valid, flush, out_ready;
  logic [31:0] in_insn;
  logic [63:0] in_pc;

  logic r64, v64, rw64, mr64, mw64, mu64, br64, jp64, asi64, il64;
  logic [63:0] pc64, imm64;
  logic [4:0]  rd64, rsa64, rsb64;
  logic [1:0]  ms64;
  logic [3:0]  op64;
  logic [CW-1:0] cnt64;

  logic r32, v32, rw32, mr32, mw32, mu32, br32, jp32, asi32, il32;
  logic [31:0] pc32, imm32;
  logic [4:0]  rd32, rsa32, rsb32;
  logic [1:0]  ms32;
  logic [3:0]  op32;
  logic [CW-1:0] cnt32;

  bundle_t act64, act32;
  pair_t   sbq [$];
  int      n_cmp = 0;
  int      n_bad = 0;
  int      exp_cnt64 = 0;
  int      exp_cnt32 = 0;

  decode_stage #(.XLEN(64), .CNT_W(CW)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64),
    .in_insn(in_insn), .in_pc(in_pc), .flush(flush), .out_valid(v64),
    .out_ready(out_ready), .out_pc(pc64), .out_rd(rd64), .out_rs1(rsa64),
    .out_rs2(rsb64), .out_imm(imm64), .out_reg_write(rw64), .out_mem_read(mr64),
    .out_mem_write(mw64), .out_mem_unsigned(mu64), .out_branch(br64),
    .out_jump(jp64), .out_alu_src_imm(asi64), .out_illegal(il64),
    .out_mem_size(ms64), .out_alu_op(op64), .illegal_count(cnt64));

  decode_stage #(.XLEN(32), .CNT_W(CW)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32),
    .in_insn(in_insn), .in_pc(in_pc[31:0]), .flush(flush), .out_valid(v32),
    .out_ready(out_ready), .out_pc(pc32), .out_rd(rd32), .out_rs1(rsa32),
    .out_rs2(rsb32), .out_imm(imm32), .out_reg_write(rw32), .out_mem_read(mr32),
    .out_mem_write(mw32), .out_mem_unsigned(mu32), .out_branch(br32),
    .out_jump(jp32), .out_alu_src_imm(asi32), .out_illegal(il32),
    .out_mem_size(ms32), .out_alu_op(op32), .illegal_count(cnt32));

  assign act64 = {pc64, rd64, rsa64, rsb64, imm64, rw64, mr64, mw64, mu64,
                  br64, jp64, asi64, il64, ms64, op64};
  assign act32 = {32'b0, pc32, rd32, rsa32, rsb32, 32'b0, imm32, rw32, mr32,
                  mw32, mu32, br32, jp32, asi32, il32, ms32, op32};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference decoder: immediates by signed arithmetic, legality by
  // instruction-set membership rules.
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [63:0] pc, input int xl);
    bundle_t b;
    int      f3, f7, alu;
    longint  sx, imm;
    bit      ok;
    int      alu_tbl [8];
    alu_tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    sx  = longint'($signed(w));
    b   = '0;
    ok  = 1'b1;
    alu = 0;
    imm = 0;
    case (w[6:0])
      7'b0000011: begin
        ok = (xl == 64) ? (f3 != 7) : (f3 inside {0, 1, 2, 4, 5});
        b.mem_read = 1; b.reg_write = 1; b.alu_src_imm = 1;
        b.mem_size = 2'(f3 % 4); b.mem_unsigned = (f3 >= 4);
        imm = sx >>> 20;
      end
      7'b0100011: begin
        ok = f3 < ((xl == 64) ? 4 : 3);
        b.mem_write = 1; b.alu_src_imm = 1; b.mem_size = 2'(f3 % 4);
        imm = ((sx >>> 25) * 32) + longint'(w[11:7]);
      end
      7'b0010011: begin
        b.reg_write = 1; b.alu_src_imm = 1; imm = sx >>> 20;
        alu = alu_tbl[f3];
        if (f3 == 1) ok = (w[31:26] == 6'd0);
        if (f3 == 5) begin
          ok = (w[31:26] == 6'd0) || (w[31:26] == 6'd16);
          if (w[30]) alu = 7;
        end
        if ((f3 == 1 || f3 == 5) && xl == 32 && w[25]) ok = 0;
      end
      7'b0110011: begin
        b.reg_write = 1; alu = alu_tbl[f3];
        if (f7 == 32) begin
          ok = (f3 == 0 || f3 == 5);
          alu = (f3 == 0) ? 1 : 7;
        end else ok = (f7 == 0);
      end
      7'b0110111: begin b.reg_write = 1; b.alu_src_imm = 1; alu = 10; imm = (sx >>> 12) * 4096; end
      7'b0010111: begin b.reg_write = 1; b.alu_src_imm = 1; imm = (sx >>> 12) * 4096; end
      7'b1101111: begin
        b.reg_write = 1; b.jump = 1; b.alu_src_imm = 1;
        imm = ((sx >>> 31) * 1048576) + longint'(w[19:12]) * 4096 +
              longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
      end
      7'b1100111: begin
        ok = (f3 == 0); b.reg_write = 1; b.jump = 1; b.alu_src_imm = 1; imm = sx >>> 20;
      end
      7'b1100011: begin
        ok = !(f3 == 2 || f3 == 3); b.branch = 1;
        alu = (f3 < 2) ? 1 : ((f3 < 6) ? 3 : 4);
        imm = ((sx >>> 31) * 4096) + longint'(w[7]) * 2048 +
              longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
      end
      default: ok = 0;
    endcase
    b.alu_op = 4'(alu);
    b.imm    = imm;
    if (!ok) begin b = '0; b.illegal = 1; end
    b.pc = pc; b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20];
    if (b.rd == 0) b.reg_write = 0;
    if (xl == 32) begin b.pc[63:32] = 0; b.imm[63:32] = 0; end
    return b;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [6:0]  ops [9];
    logic [31:0] w;
    int          k;
    ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) w[6:0] = ops[k];
    if (k == 2 && $urandom_range(0, 3) != 0) w[31:26] = ($urandom_range(0, 1) == 1) ? 6'd16 : 6'd0;
    if (k == 3 && $urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'd32 : 7'd0;
    if (k == 7 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
    return w;
  endfunction

  // One clock of stimulus; the scoreboard is updated after the monitor's
  // negedge look so a same-cycle drain is retired before capture/flush/reset.
  task automatic step(input logic v, input logic [31:0] insn, input logic fl,
                      input logic ordy, input logic rs);
    logic [63:0] pc;
    logic        cap;
    pair_t       p;
    pc = {$urandom, $urandom};
    in_valid = v; in_insn = insn; in_pc = pc; flush = fl; out_ready = ordy; rst_n = rs;
    cap = rs && !fl && v && (sbq.size() == 0 || ordy);
    @(negedge clk);
    #1;
    if (!rs) begin
      sbq.delete(); exp_cnt64 = 0; exp_cnt32 = 0;
    end else if (fl) begin
      sbq.delete();
    end else if (cap) begin
      p.e64 = ref_decode(insn, pc, 64);
      p.e32 = ref_decode(insn, pc, 32);
      sbq.push_back(p);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    chk("rst_bundle64", 256'(act64), 256'(0));
    chk("rst_bundle32", 256'(act32), 256'(0));
    chk("rst_valid",    256'({v64, v32}), 256'(0));
    chk("rst_count",    256'({cnt64, cnt32}), 256'(0));
    chk("rst_in_ready", 256'({r64, r32}), 256'(2'b11));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic ev;
    ev = (sbq.size() != 0);
    chk("out_valid64", 256'(v64), 256'(ev));
    chk("out_valid32", 256'(v32), 256'(ev));
    chk("in_ready", 256'({r64, r32}), 256'({2{!ev || out_ready}}));
    chk("illegal_count64", 256'(cnt64), 256'(exp_cnt64));
    chk("illegal_count32", 256'(cnt32), 256'(exp_cnt32));
    if (ev) begin
      chk("bundle64", 256'(act64), 256'(sbq[0].e64));
      chk("bundle32", 256'(act32), 256'(sbq[0].e32));
      if (out_ready) begin
        if (sbq[0].e64.illegal && exp_cnt64 < (1 << CW) - 1) exp_cnt64++;
        if (sbq[0].e32.illegal && exp_cnt32 < (1 << CW) - 1) exp_cnt32++;
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    in_valid = 0; in_insn = 0; in_pc = 0; flush = 0; out_ready = 1; rst_n = 0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 1, 0);
    check_reset_state();

    // LD x1,0(x1): legal on RV64, illegal on RV32
    step(1, 32'h0000B083, 0, 1, 1);
    chk("ld64_valid", 256'(v64), 256'(1));
    chk("ld64_ctl", 256'({mr64, rw64, ms64, il64}), 256'({1'b1, 1'b1, 2'd3, 1'b0}));
    chk("ld64_imm", 256'(imm64), 256'(0));
    chk("ld32_illegal", 256'(il32), 256'(1));
    chk("ld32_enables", 256'({rw32, mr32, mw32, br32, jp32}), 256'(0));
    step(0, 0, 0, 1, 1);
    chk("ld_count", 256'({cnt64, cnt32}), 256'({4'd0, 4'd1}));

    // BEQ x0,x0,-4
    step(1, 32'hFE000EE3, 0, 1, 1);
    chk("beq_ctl", 256'({br64, op64}), 256'({1'b1, 4'd1}));
    chk("beq_imm64", 256'(imm64), 256'(64'hFFFF_FFFF_FFFF_FFFC));
    chk("beq_imm32", 256'(imm32), 256'(32'hFFFF_FFFC));

    // Backpressure then streaming
    step(1, rand_insn(), 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, rand_insn(), 0, 0, 1);
      chk("stall_in_ready", 256'({r64, r32}), 256'(0));
    end
    for (int i = 0; i < 6; i++) step(1, rand_insn(), 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // Flush with a held bundle and a new one arriving
    step(1, rand_insn(), 0, 0, 1);
    step(1, rand_insn(), 1, 0, 1);
    chk("flush_valid", 256'({v64, v32}), 256'(0));
    step(0, 0, 0, 1, 1);

    // Counter saturation with 20 illegal words
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, $urandom & 32'hFFFF_FFFC, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk("sat_count", 256'({cnt64, cnt32}), 256'({4'hF, 4'hF}));

    // Reset with a bundle in flight
    step(1, rand_insn(), 0, 0, 1);
    step(1, rand_insn(), 0, 0, 0);
    check_reset_state();

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_insn(), $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 149) != 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
